// File: rtl/aud_dsp_pkg.sv
// Shared types and helpers for the multi-channel variable-speed audio sample processor.
package aud_dsp_pkg;

    localparam int AUD_DW_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_FETCH,
        S_DIV,
        S_STEP,
        S_DONE
    } state_t;

    // Width needed to hold any ratio 0..max_ratio.
    function automatic int ratio_w(input int max_ratio);
        return $clog2(max_ratio + 1);
    endfunction

endpackage

// File: rtl/aud_div_seq.sv
// Sequential restoring divider: signed DW+1-bit dividend by unsigned RW-bit divisor, DW+2 cycles.
// With AUD_DSP_ROUND_EN defined the quotient rounds to nearest (ties away from zero), else truncates.
module aud_div_seq #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic signed [DW:0]   i_dividend,
    input  logic [RW-1:0]        i_divisor,
    output logic                 o_done,
    output logic [DW-1:0]        o_quot
);

    localparam int CNTW = $clog2(DW + 2);
    localparam logic [CNTW-1:0] LAST = CNTW'(DW + 1);

    logic            busy, neg, fits, rnd;
    logic [CNTW-1:0] cnt;
    logic [DW:0]     quo;
    logic [RW-1:0]   rem, dvs;
    logic [RW:0]     trial, trial_sub;
    logic [DW-1:0]   qmag;

    // Magnitude bits shift out of quo's MSB while quotient bits shift in at the LSB.
    always_comb begin
        trial     = {rem, quo[DW]};
        trial_sub = trial - {1'b0, dvs};
        fits      = (trial >= {1'b0, dvs});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy <= 1'b0;
            neg  <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (i_clear) begin
            busy <= 1'b0;
            neg  <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (i_start) begin
            busy <= 1'b1;
            cnt  <= '0;
            neg  <= i_dividend[DW];
            quo  <= i_dividend[DW] ? -i_dividend : i_dividend;
            rem  <= '0;
            dvs  <= i_divisor;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CNTW'(1);
                rem <= fits ? trial_sub[RW-1:0] : trial[RW-1:0];
                quo <= {quo[DW-1:0], fits};
            end
        end
    end

`ifdef AUD_DSP_ROUND_EN
    assign rnd = ({rem, 1'b0} >= {1'b0, dvs});
`else
    assign rnd = 1'b0;
`endif

    assign qmag   = quo[DW-1:0] + {{(DW-1){1'b0}}, rnd};
    assign o_quot = neg ? -qmag : qmag;
    assign o_done = busy && (cnt == LAST);

endmodule

// File: rtl/aud_dsp_mc.sv
// Multi-channel variable-speed audio processor: record pass-through, fast skip, slow hold/interpolate.
// Optional AUD_DSP_ROUND_EN (in aud_div_seq) selects rounded instead of truncated interpolation step.
module aud_dsp_mc import aud_dsp_pkg::*; #(
    parameter int DW        = AUD_DW_DEF,
    parameter int CH        = 2,
    parameter int MAX_RATIO = 8,
    parameter int RW        = ratio_w(MAX_RATIO)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic             i_fast,
    input  logic [RW-1:0]    i_ratio,
    input  logic             i_interpol,
    input  logic             i_start,
    output logic             o_fin,
    output logic             o_busy,
    output logic [RW-1:0]    o_next_num,
    output logic             o_mem_start,
    input  logic             i_mem_fin,
    input  logic [CH*DW-1:0] i_rdata,
    output logic [CH*DW-1:0] o_dac_data,
    input  logic [CH*DW-1:0] i_adc_data,
    output logic [CH*DW-1:0] o_wdata
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);
    localparam logic [RW-1:0] R_ONE   = RW'(1);
    localparam logic [RW-1:0] R_MAX   = RW'(MAX_RATIO);

    state_t                 state, state_n;
    logic [RW-1:0]          k, ratio_q, ratio_eff;
    logic                   slow_q, interp_q, slow_n, mem_start_q;
    logic [CW-1:0]          ch_idx, ch_n;
    logic [CH-1:0][DW-1:0]  rd_v, cur, prev, acc, delta, acc_nx;
    logic                   div_first, div_start, div_done;
    logic [DW-1:0]          sub_a, sub_b, quot;
    logic signed [DW:0]     dividend;

    assign rd_v = i_rdata;

    always_comb begin
        if (i_ratio == '0)
            ratio_eff = R_ONE;
        else if (i_ratio > R_MAX)
            ratio_eff = R_MAX;
        else
            ratio_eff = i_ratio;
        slow_n = !i_fast && (ratio_eff != R_ONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else if (i_clear)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_start) state_n = i_mode ? S_REC : ((k == '0) ? S_FETCH : S_STEP);
            S_REC:   if (i_mem_fin) state_n = S_DONE;
            S_FETCH: if (i_mem_fin) state_n = slow_q ? S_DIV : S_DONE;
            S_DIV:   if (div_done && ch_idx == CH_LAST) state_n = S_DONE;
            S_STEP:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != S_IDLE);
        o_fin  = (state == S_DONE);
    end

    assign o_mem_start = mem_start_q;

    // Channel 0 division launches on the fetch edge from the incoming frame; the rest chain off o_done.
    always_comb begin
        ch_n      = ch_idx + CW'(1);
        div_first = (state == S_FETCH) && i_mem_fin && slow_q;
        div_start = div_first || ((state == S_DIV) && div_done && (ch_idx != CH_LAST));
        sub_a     = div_first ? rd_v[0] : cur[ch_n];
        sub_b     = div_first ? cur[0]  : prev[ch_n];
        dividend  = $signed({sub_a[DW-1], sub_a}) - $signed({sub_b[DW-1], sub_b});
        for (int c = 0; c < CH; c++)
            acc_nx[c] = acc[c] + delta[c];
    end

    aud_div_seq #(.DW(DW), .RW(RW)) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_start    (div_start),
        .i_dividend (dividend),
        .i_divisor  (ratio_q),
        .o_done     (div_done),
        .o_quot     (quot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k           <= '0;
            ratio_q     <= '0;
            slow_q      <= 1'b0;
            interp_q    <= 1'b0;
            mem_start_q <= 1'b0;
            ch_idx      <= '0;
            cur         <= '0;
            prev        <= '0;
            acc         <= '0;
            delta       <= '0;
            o_next_num  <= '0;
            o_dac_data  <= '0;
            o_wdata     <= '0;
        end else if (i_clear) begin
            k           <= '0;
            ratio_q     <= '0;
            slow_q      <= 1'b0;
            interp_q    <= 1'b0;
            mem_start_q <= 1'b0;
            ch_idx      <= '0;
            cur         <= '0;
            prev        <= '0;
            acc         <= '0;
            delta       <= '0;
            o_next_num  <= '0;
            o_dac_data  <= '0;
            o_wdata     <= '0;
        end else begin
            mem_start_q <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    if (i_mode) begin
                        o_wdata     <= i_adc_data;
                        k           <= '0;
                        mem_start_q <= 1'b1;
                    end else if (k == '0) begin
                        // Segment parameters are frozen here until k wraps back to 0.
                        ratio_q     <= ratio_eff;
                        slow_q      <= slow_n;
                        interp_q    <= i_interpol;
                        o_next_num  <= slow_n ? '0 : ratio_eff - R_ONE;
                        mem_start_q <= 1'b1;
                    end
                end
                S_FETCH: if (i_mem_fin) begin
                    cur    <= rd_v;
                    ch_idx <= '0;
                    if (slow_q)
                        prev <= cur;
                    else
                        o_dac_data <= i_rdata;
                end
                S_DIV: if (div_done) begin
                    delta[ch_idx] <= interp_q ? quot : '0;
                    acc[ch_idx]   <= prev[ch_idx];
                    if (ch_idx == CH_LAST) begin
                        k          <= R_ONE;
                        o_dac_data <= prev;
                    end else begin
                        ch_idx <= ch_n;
                    end
                end
                S_STEP: begin
                    acc        <= acc_nx;
                    o_dac_data <= acc_nx;
                    k          <= (k == ratio_q - R_ONE) ? '0 : k + R_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aud_dsp_mc.md
Name: aud_dsp_mc

Overview:
- Multi-channel, parametrised variable-speed audio sample processor between the SRAM sequencer and the I2S/DAC path.
- Record mode: forwards ADC frames to memory.
- Play mode: fast playback by sample skipping, or slow playback by sample repetition, with zero-order hold or signed linear interpolation.
- Generalises the single-channel 16-bit processor to DW bits, CH channels and ratios up to MAX_RATIO, and adds correct signed interpolation through a shared sequential divider.

Parameters:
- DW, 16, sample width per channel (two's complement).
- CH, 2, channels packed per frame; channel 0 in the LSBs.
- MAX_RATIO, 8, maximum speed-up or slow-down factor. RW = $clog2(MAX_RATIO+1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clear  in  1  synchronous clear, same effect as reset
- i_mode  in  1  0 play, 1 record
- i_fast  in  1  1 fast (skip), 0 slow (repeat/interpolate)
- i_ratio  in  RW  factor; 0 treated as 1, values above MAX_RATIO clamped to MAX_RATIO
- i_interpol  in  1  0 zero-order hold, 1 linear interpolation
- i_start  in  1  one-cycle request for the next output frame
- o_fin  out  1  one-cycle pulse: frame done, outputs valid
- o_busy  out  1  high whenever state != IDLE
- o_next_num  out  RW  memory advance minus 1 for the next fetch
- o_mem_start  out  1  one-cycle memory request
- i_mem_fin  in  1  memory access complete
- i_rdata  in  CH*DW  frame read from memory
- o_dac_data  out  CH*DW  frame to DAC
- i_adc_data  in  CH*DW  frame from ADC
- o_wdata  out  CH*DW  frame to memory

Behaviour:
- Reset/clear: state IDLE; counter k, cur, prev, acc, delta, o_wdata = 0; o_dac_data = 0; all single-bit outputs 0; o_next_num = 0. Clear mid-operation aborts the divider; the next i_start behaves as after reset.
- States: IDLE, REC, FETCH, DIV, STEP, DONE.
- i_start is accepted only in IDLE and ignored while o_busy. i_mem_fin is ignored outside REC and FETCH.
- Mode and ratio are sampled at i_start only when k==0. Mid-segment (k!=0) changes are ignored until the segment wraps.
- A record start with k!=0 forces k=0.
- Record: IDLE -> REC; o_wdata <= i_adc_data; o_mem_start pulses in the first REC cycle. On i_mem_fin -> DONE. DONE pulses o_fin one cycle -> IDLE.
- Fast, or ratio==1: o_next_num <= ratio-1; o_mem_start pulse; FETCH. On i_mem_fin: cur <= i_rdata, o_dac_data = cur -> DONE.
  - Latency: start to fin = memory latency + 2 cycles.
- Slow, ratio R>1, k==0: o_next_num <= 0; FETCH. On i_mem_fin: prev <= cur, cur <= i_rdata -> DIV.
  - DIV, per channel sequentially: diff = cur-prev as DW+1-bit signed value. delta[ch] = diff/R (truncated toward zero) if i_interpol, else 0. acc[ch] <= prev[ch].
  - After the last channel -> DONE; k <= 1.
  - DIV length: CH*(DW+2) cycles.
- Slow, k!=0: STEP: acc += delta per channel (DW-bit wrap, cannot overflow since |k*delta| <= |diff|). k <= (k==R-1) ? 0 : k+1 -> DONE.
  - Latency: start to fin = 2 cycles.
- Slow output: o_dac_data = acc. The output lags memory by one frame. Sequence per segment: prev, prev+d, ..., prev+(R-1)d.

Optional Feature:
- Macro AUD_DSP_ROUND_EN.
- Defined: the divider rounds to nearest, ties away from zero.
- Undefined: truncation toward zero.
- Timing is the same either way.

Decomposition:
- aud_dsp_pkg: state enum, function to compute RW, default DW.
- Sub-module aud_div_seq: signed dividend DW+1, unsigned divisor RW, restoring algorithm, i_start/o_done, DW+2 cycles. It carries the AUD_DSP_ROUND_EN logic.

Test Plan:
1. Record, CH=2, i_adc_data=0x1234_ABCD: o_wdata=0x1234_ABCD, single o_mem_start pulse, o_fin one cycle after i_mem_fin, o_dac_data unchanged.
2. Fast, ratio 3, i_rdata=0x0100_0200: o_next_num=2, o_dac_data=0x0100_0200, o_fin = memory latency + 2 cycles after start.
3. Slow R=4, interpol=1, ch0:
   - Fetch 0x0100, then 0xFF00; the second segment outputs 0x0100, 0x0080, 0x0000, 0xFF80.
   - o_mem_start only on the k==0 starts.
4. Slow R=4, interpol=0: four consecutive outputs equal prev; the ratio changed to 2 mid-segment is ignored until the wrap.
5. R=2, diff=-5 from prev 0: second output 0xFFFE without the macro, 0xFFFD with AUD_DSP_ROUND_EN.
6. i_clear asserted during DIV: IDLE next cycle, all outputs 0. A following slow start fetches with prev=0.
   - Also check: i_start during busy and a spurious i_mem_fin in IDLE have no effect.
